mqnic_mac_ctrl_rx: RTL and testbench

MQNIC_MAC_CTRL_RX -- requirements
Module: mqnic_mac_ctrl_rx

---
 rtl/mqnic_mac_ctrl_rx.sv | 198 +++++++++++++++++++
 tb/tb_mqnic_mac_ctrl_rx.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mqnic_mac_ctrl_rx.sv
// MAC control receive path: strips MAC control frames from the ingress stream and
// decodes 802.3x / PFC pause frames; all other frames pass through a one-stage slice.
module mqnic_mac_ctrl_rx #(
  parameter int unsigned AXIS_DATA_WIDTH = 256,
  parameter int unsigned AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int unsigned AXIS_USER_WIDTH = 1,
  parameter int unsigned AXIS_USE_READY  = 0
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  input  logic [AXIS_USER_WIDTH-1:0] s_axis_tuser,

  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [AXIS_USER_WIDTH-1:0] m_axis_tuser,

  output logic                       rx_pause_valid,
  output logic                       rx_pause_type,
  output logic [7:0]                 rx_pause_enable,
  output logic [127:0]               rx_pause_quanta,

  output logic                       stat_rx_mcf,
  output logic                       stat_rx_mcf_err
);

  localparam int unsigned KW        = AXIS_KEEP_WIDTH;
  localparam int unsigned HDR_BYTES = 34;
  localparam int unsigned LEN_W     = 16;
  localparam bit          USE_RDY   = (AXIS_USE_READY != 0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FWD  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [1:0]             r_beat_cnt;
  logic [7:0]             r_hdr [HDR_BYTES];
  logic [7:0]             w_hdr [HDR_BYTES];

  logic                   r_m_tvalid;
  logic [AXIS_DATA_WIDTH-1:0] r_m_tdata;
  logic [AXIS_KEEP_WIDTH-1:0] r_m_tkeep;
  logic                   r_m_tlast;
  logic [AXIS_USER_WIDTH-1:0] r_m_tuser;

  logic                   r_pause_valid;
  logic                   r_pause_type;
  logic [7:0]             r_pause_enable;
  logic [127:0]           r_pause_quanta;
  logic                   r_mcf;
  logic                   r_mcf_err;

  logic                   w_s_tready;
  logic                   w_accept;
  logic                   w_first;
  logic                   w_is_mcf;
  logic                   w_fwd_beat;
  logic                   w_mcf_end;
  logic                   w_capture;
  logic [LEN_W-1:0]       w_last_bytes;
  logic [LEN_W-1:0]       w_frame_len;
  logic                   w_dst_ok;
  logic [15:0]            w_opcode;
  logic                   w_is_8023x;
  logic                   w_is_pfc;
  logic                   w_pause_ok;
  logic [127:0]           w_quanta;

  // Beat classification and handshake
  assign w_first    = (r_state == ST_IDLE);
  assign w_is_mcf   = (s_axis_tdata[8*12 +: 8] == 8'h88) && (s_axis_tdata[8*13 +: 8] == 8'h08);
  assign w_s_tready = rst && ((r_state == ST_DROP) || m_axis_tready || !r_m_tvalid);
  assign w_accept   = USE_RDY ? (s_axis_tvalid && w_s_tready) : s_axis_tvalid;
  assign w_fwd_beat = w_accept && ((w_first && !w_is_mcf) || (r_state == ST_FWD));
  assign w_mcf_end  = w_accept && s_axis_tlast && ((w_first && w_is_mcf) || (r_state == ST_DROP));
  assign w_capture  = w_accept && (w_first || (r_state == ST_DROP));

  assign s_axis_tready = w_s_tready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && !s_axis_tlast) w_state_nxt = w_is_mcf ? ST_DROP : ST_FWD;
      ST_FWD,
      ST_DROP: if (w_accept && s_axis_tlast) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Beats already accepted in the current frame, saturating once the header is complete
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat_cnt <= 2'd0;
    end else if (w_accept) begin
      if (s_axis_tlast)             r_beat_cnt <= 2'd0;
      else if (r_beat_cnt != 2'd3)  r_beat_cnt <= r_beat_cnt + 2'd1;
    end
  end

  // Header view including the current beat, so single-beat frames decode too
  always_comb begin
    for (int unsigned i = 0; i < HDR_BYTES; i++) begin
      w_hdr[i] = r_hdr[i];
      if (w_capture && (32'(r_beat_cnt) == (i / KW))) w_hdr[i] = s_axis_tdata[8*(i % KW) +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) r_hdr <= w_hdr;
  end

  always_comb begin
    w_last_bytes = '0;
    for (int unsigned i = 0; i < KW; i++) w_last_bytes = w_last_bytes + LEN_W'(s_axis_tkeep[i]);
  end

  assign w_frame_len = LEN_W'(r_beat_cnt) * LEN_W'(KW) + w_last_bytes;
  assign w_dst_ok    = {w_hdr[0], w_hdr[1], w_hdr[2], w_hdr[3], w_hdr[4], w_hdr[5]} == 48'h0180C2000001;
  assign w_opcode    = {w_hdr[14], w_hdr[15]};
  assign w_is_8023x  = (w_opcode == 16'h0001);
  assign w_is_pfc    = (w_opcode == 16'h0101);
  assign w_pause_ok  = w_dst_ok && (w_is_8023x || w_is_pfc) &&
                       (w_frame_len >= LEN_W'(HDR_BYTES)) && !s_axis_tuser[0];

  always_comb begin
    w_quanta = '0;
    for (int unsigned n = 0; n < 8; n++) begin
      if (w_is_pfc) w_quanta[16*n +: 16] = {w_hdr[18 + 2*n], w_hdr[19 + 2*n]};
      else          w_quanta[16*n +: 16] = {w_hdr[16], w_hdr[17]};
    end
  end

  // Output register slice for data frames
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               r_m_tvalid <= 1'b0;
    else if (w_fwd_beat)    r_m_tvalid <= 1'b1;
    else if (m_axis_tready) r_m_tvalid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_fwd_beat) begin
      r_m_tdata <= s_axis_tdata;
      r_m_tkeep <= s_axis_tkeep;
      r_m_tlast <= s_axis_tlast;
      r_m_tuser <= s_axis_tuser;
    end
  end

  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tkeep  = r_m_tkeep;
  assign m_axis_tlast  = r_m_tlast;
  assign m_axis_tuser  = r_m_tuser;

  // Pause decode results; pause fields only move on a valid pause frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mcf          <= 1'b0;
      r_mcf_err      <= 1'b0;
      r_pause_valid  <= 1'b0;
      r_pause_type   <= 1'b0;
      r_pause_enable <= 8'h00;
      r_pause_quanta <= '0;
    end else begin
      r_mcf         <= w_mcf_end;
      r_mcf_err     <= w_mcf_end && !w_pause_ok;
      r_pause_valid <= w_mcf_end && w_pause_ok;
      if (w_mcf_end && w_pause_ok) begin
        r_pause_type   <= w_is_pfc;
        r_pause_enable <= w_is_pfc ? w_hdr[17] : 8'hFF;
        r_pause_quanta <= w_quanta;
      end
    end
  end

  assign stat_rx_mcf     = r_mcf;
  assign stat_rx_mcf_err = r_mcf_err;
  assign rx_pause_valid  = r_pause_valid;
  assign rx_pause_type   = r_pause_type;
  assign rx_pause_enable = r_pause_enable;
  assign rx_pause_quanta = r_pause_quanta;

endmodule

// File: tb/tb_mqnic_mac_ctrl_rx.sv
// Bench for mqnic_mac_ctrl_rx (128-bit stream, ready honoured): frame-level model of
// forwarding and pause decode, checked every cycle, plus literal spot checks.
module tb_mqnic_mac_ctrl_rx;

  localparam int unsigned DW = 128;
  localparam int unsigned KW = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [DW-1:0]  s_axis_tdata = '0;
  logic [KW-1:0]  s_axis_tkeep = '0;
  logic           s_axis_tvalid = 1'b0;
  logic           s_axis_tready;
  logic           s_axis_tlast = 1'b0;
  logic [0:0]     s_axis_tuser = '0;
  logic [DW-1:0]  m_axis_tdata;
  logic [KW-1:0]  m_axis_tkeep;
  logic           m_axis_tvalid;
  logic           m_axis_tready = 1'b1;
  logic           m_axis_tlast;
  logic [0:0]     m_axis_tuser;
  logic           rx_pause_valid;
  logic           rx_pause_type;
  logic [7:0]     rx_pause_enable;
  logic [127:0]   rx_pause_quanta;
  logic           stat_rx_mcf;
  logic           stat_rx_mcf_err;

  always #5 clk = ~clk;

  mqnic_mac_ctrl_rx #(
    .AXIS_DATA_WIDTH(DW),
    .AXIS_KEEP_WIDTH(KW),
    .AXIS_USER_WIDTH(1),
    .AXIS_USE_READY(1)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .rx_pause_valid(rx_pause_valid), .rx_pause_type(rx_pause_type),
    .rx_pause_enable(rx_pause_enable), .rx_pause_quanta(rx_pause_quanta),
    .stat_rx_mcf(stat_rx_mcf), .stat_rx_mcf_err(stat_rx_mcf_err)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic          u;
  } beat_t;

  int unsigned  n_chk  = 0;
  int unsigned  n_pass = 0;
  beat_t        exp_q[$];
  logic [7:0]   fb [0:255];
  bit           strict_lat = 1'b0;
  bit           bp_mode    = 1'b0;

  // Model state: pending decode result for the next cycle, and held pause outputs
  bit           pend = 1'b0;
  bit           pend_valid;
  bit           pend_type;
  logic [7:0]   pend_en;
  logic [127:0] pend_q;
  logic         exp_type   = 1'b0;
  logic [7:0]   exp_en     = 8'h00;
  logic [127:0] exp_quanta = '0;
  bit           seen_mcf, seen_err, seen_valid;
  int unsigned  n_out = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // Downstream ready: steady 1, or alternating every cycle under backpressure
  always @(posedge clk) begin
    #1;
    m_axis_tready = bp_mode ? ~m_axis_tready : 1'b1;
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_m_tvalid", 256'(m_axis_tvalid), 256'(0));
      chk("rst_s_tready", 256'(s_axis_tready), 256'(0));
      chk("rst_strobes", 256'({rx_pause_valid, stat_rx_mcf, stat_rx_mcf_err}), 256'(0));
      chk("rst_pause_regs", 256'({rx_pause_type, rx_pause_enable, rx_pause_quanta}), 256'(0));
    end else begin
      if (pend && pend_valid) begin
        exp_type   = pend_type;
        exp_en     = pend_en;
        exp_quanta = pend_q;
      end
      chk("strobes", 256'({rx_pause_valid, stat_rx_mcf, stat_rx_mcf_err}),
          256'({pend && pend_valid, pend, pend && !pend_valid}));
      chk("pause_regs", 256'({rx_pause_type, rx_pause_enable, rx_pause_quanta}),
          256'({exp_type, exp_en, exp_quanta}));
      seen_mcf   |= stat_rx_mcf;
      seen_err   |= stat_rx_mcf_err;
      seen_valid |= rx_pause_valid;
      pend = 1'b0;
      if (strict_lat) chk("fwd_latency_no_gap", 256'(m_axis_tvalid), 256'(exp_q.size() != 0));
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_m_beat: got data %h, required no beat", m_axis_tdata);
        end else begin
          chk("m_beat", 256'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}),
              256'(exp_q.pop_front()));
          n_out++;
        end
      end
    end
  end

  // Expected decode of a control frame, straight from the frame bytes
  task automatic model_mcf(input int len, input bit err);
    logic [15:0] op;
    bit          dst;
    dst = (fb[0] == 8'h01) && (fb[1] == 8'h80) && (fb[2] == 8'hC2) &&
          (fb[3] == 8'h00) && (fb[4] == 8'h00) && (fb[5] == 8'h01);
    op  = {fb[14], fb[15]};
    pend_valid = dst && (op == 16'h0001 || op == 16'h0101) && (len >= 34) && !err;
    pend_type  = (op == 16'h0101);
    pend_en    = pend_type ? fb[17] : 8'hFF;
    for (int n = 0; n < 8; n++)
      pend_q[16*n +: 16] = pend_type ? {fb[18+2*n], fb[19+2*n]} : {fb[16], fb[17]};
    pend = 1'b1;
  endtask

  // Sends fb[0:len-1]; with abort_at >= 0, leaves that beat presented and returns
  task automatic send_frame(input int len, input bit err, input int abort_at);
    int nb;
    bit mcf;
    nb  = (len + KW - 1) / KW;
    mcf = (fb[12] == 8'h88) && (fb[13] == 8'h08);
    for (int b = 0; b < nb; b++) begin
      beat_t bt;
      bit    acc, r;
      bt = '0;
      for (int j = 0; j < KW; j++) begin
        if (b*KW + j < len) begin
          bt.d[8*j +: 8] = fb[b*KW + j];
          bt.k[j] = 1'b1;
        end
      end
      bt.l = (b == nb - 1);
      bt.u = err && bt.l;
      s_axis_tdata  = bt.d;
      s_axis_tkeep  = bt.k;
      s_axis_tlast  = bt.l;
      s_axis_tuser  = bt.u;
      s_axis_tvalid = 1'b1;
      if (b == abort_at) return;
      acc = 1'b0;
      for (int t = 0; t < 100 && !acc; t++) begin
        @(negedge clk);
        r = s_axis_tready;
        if (t == 0 && mcf && b > 0) chk("mcf_drop_tready", 256'(r), 256'(1));
        @(posedge clk);
        acc = r;
      end
      #1;
      if (!acc) begin
        n_chk++;
        $display("FAIL s_accept_timeout: beat %0d not accepted, required acceptance", b);
      end else begin
        if (!mcf) exp_q.push_back(bt);
        if (bt.l && mcf) model_mcf(len, err);
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = '0;
  endtask

  task automatic build_data(input int len, input logic [7:0] seed);
    for (int i = 0; i < 256; i++) fb[i] = 8'(seed + 8'(i * 7));
    fb[0] = 8'h00; fb[1] = 8'h11; fb[2] = 8'h22; fb[3] = 8'h33; fb[4] = 8'h44; fb[5] = 8'h55;
    fb[12] = 8'h08; fb[13] = 8'h00;
    if (len < 0) fb[0] = 8'h00;
  endtask

  task automatic build_mcf(input logic [47:0] dst, input logic [15:0] op,
                           input logic [7:0] b16, input logic [7:0] b17, input logic [127:0] q);
    for (int i = 0; i < 256; i++) fb[i] = 8'h00;
    for (int i = 0; i < 6; i++) fb[i] = dst[8*(5-i) +: 8];
    for (int i = 6; i < 12; i++) fb[i] = 8'(8'hA0 + 8'(i));
    fb[12] = 8'h88; fb[13] = 8'h08;
    fb[14] = op[15:8]; fb[15] = op[7:0];
    fb[16] = b16; fb[17] = b17;
    for (int n = 0; n < 8; n++) begin
      fb[18+2*n] = q[16*n+8 +: 8];
      fb[19+2*n] = q[16*n +: 8];
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_seen();
    seen_mcf = 1'b0; seen_err = 1'b0; seen_valid = 1'b0; n_out = 0;
  endtask

  localparam logic [47:0] PAUSE_DA = 48'h0180C2000001;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, required completion");
    $fatal(1);
  end

  initial begin
    logic [127:0] q;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_m_tvalid", 256'(m_axis_tvalid), 256'(0));
    chk("reset_s_tready", 256'(s_axis_tready), 256'(0));
    chk("reset_pause_enable", 256'(rx_pause_enable), 256'(0));
    #1 rst = 1'b1;
    idle(2);

    // 3-beat IPv4 frame, continuous ready: 1-cycle latency, no gaps
    clear_seen();
    strict_lat = 1'b1;
    build_data(48, 8'h10);
    send_frame(48, 1'b0, -1);
    idle(3);
    strict_lat = 1'b0;
    chk("ipv4_beats_out", 256'(n_out), 256'(3));

    // 802.3x, quanta 0x1234, 60 bytes
    clear_seen();
    build_mcf(PAUSE_DA, 16'h0001, 8'h12, 8'h34, '0);
    send_frame(60, 1'b0, -1);
    idle(3);
    chk("x_seen_mcf", 256'(seen_mcf), 256'(1));
    chk("x_seen_valid", 256'(seen_valid), 256'(1));
    chk("x_seen_err", 256'(seen_err), 256'(0));
    chk("x_type", 256'(rx_pause_type), 256'(0));
    chk("x_enable", 256'(rx_pause_enable), 256'(8'hFF));
    chk("x_quanta", 256'(rx_pause_quanta), 256'({8{16'h1234}}));
    chk("x_no_fwd", 256'(n_out), 256'(0));

    // PFC: enable 0x05, class0 0x0010, class1 0x0102, class2 0xFFFF
    clear_seen();
    q = '0;
    q[15:0] = 16'h0010; q[31:16] = 16'h0102; q[47:32] = 16'hFFFF; q[127:112] = 16'h7777;
    build_mcf(PAUSE_DA, 16'h0101, 8'h00, 8'h05, q);
    send_frame(64, 1'b0, -1);
    idle(3);
    chk("pfc_seen_valid", 256'(seen_valid), 256'(1));
    chk("pfc_type", 256'(rx_pause_type), 256'(1));
    chk("pfc_enable", 256'(rx_pause_enable), 256'(8'h05));
    chk("pfc_q0", 256'(rx_pause_quanta[15:0]), 256'(16'h0010));
    chk("pfc_q1", 256'(rx_pause_quanta[31:16]), 256'(16'h0102));
    chk("pfc_q2", 256'(rx_pause_quanta[47:32]), 256'(16'hFFFF));
    chk("pfc_q7", 256'(rx_pause_quanta[127:112]), 256'(16'h7777));

    // PFC with tuser error on tlast: error strobe, outputs held
    clear_seen();
    build_mcf(PAUSE_DA, 16'h0101, 8'h00, 8'hAA, {8{16'hBEEF}});
    send_frame(64, 1'b1, -1);
    idle(3);
    chk("err_seen_err", 256'(seen_err), 256'(1));
    chk("err_seen_valid", 256'(seen_valid), 256'(0));
    chk("err_seen_mcf", 256'(seen_mcf), 256'(1));
    chk("err_enable_held", 256'(rx_pause_enable), 256'(8'h05));
    chk("err_q2_held", 256'(rx_pause_quanta[47:32]), 256'(16'hFFFF));

    // Length boundary: 33 bytes rejected, 34 bytes accepted
    clear_seen();
    build_mcf(PAUSE_DA, 16'h0001, 8'h55, 8'h55, '0);
    send_frame(33, 1'b0, -1);
    idle(3);
    chk("len33_err", 256'({seen_valid, seen_err}), 256'(2'b01));
    clear_seen();
    build_mcf(PAUSE_DA, 16'h0001, 8'h43, 8'h21, '0);
    send_frame(34, 1'b0, -1);
    idle(3);
    chk("len34_valid", 256'({seen_valid, seen_err}), 256'(2'b10));
    chk("len34_quanta", 256'(rx_pause_quanta), 256'({8{16'h4321}}));

    // Wrong destination, wrong opcode, single-beat control frame
    clear_seen();
    build_mcf(48'h0180C2000002, 16'h0001, 8'h11, 8'h11, '0);
    send_frame(60, 1'b0, -1);
    build_mcf(PAUSE_DA, 16'h0002, 8'h22, 8'h22, '0);
    send_frame(60, 1'b0, -1);
    build_mcf(PAUSE_DA, 16'h0001, 8'h33, 8'h33, '0);
    send_frame(16, 1'b0, -1);
    idle(3);
    chk("bad_frames_no_valid", 256'({seen_valid, seen_err, n_out}), 256'({1'b0, 1'b1, 32'd0}));
    chk("bad_frames_quanta_held", 256'(rx_pause_quanta), 256'({8{16'h4321}}));

    // Single-beat data frame stays forwardable
    clear_seen();
    build_data(14, 8'h3C);
    send_frame(14, 1'b0, -1);
    idle(3);
    chk("short_data_out", 256'(n_out), 256'(1));

    // Backpressure: data frame then control frame back to back
    clear_seen();
    bp_mode = 1'b1;
    build_data(70, 8'h61);
    send_frame(70, 1'b0, -1);
    build_mcf(PAUSE_DA, 16'h0001, 8'h0A, 8'hBC, '0);
    send_frame(64, 1'b0, -1);
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge clk);
    idle(3);
    bp_mode = 1'b0;
    idle(2);
    chk("bp_drained", 256'(exp_q.size()), 256'(0));
    chk("bp_data_beats", 256'(n_out), 256'(5));
    chk("bp_pause_quanta", 256'(rx_pause_quanta), 256'({8{16'h0ABC}}));

    // Reset during beat 2 of a 4-beat data frame, then a clean frame
    clear_seen();
    build_data(64, 8'h90);
    send_frame(64, 1'b0, 2);
    #2;
    rst = 1'b0;
    exp_q.delete();
    pend = 1'b0;
    exp_type = 1'b0; exp_en = 8'h00; exp_quanta = '0;
    #1;
    chk("midrst_m_tvalid", 256'(m_axis_tvalid), 256'(0));
    chk("midrst_s_tready", 256'(s_axis_tready), 256'(0));
    s_axis_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    idle(1);
    n_out = 0;
    build_data(48, 8'hC7);
    send_frame(48, 1'b0, -1);
    idle(3);
    chk("post_rst_beats", 256'(n_out), 256'(3));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
